// File: rtl/add_sub_pkg.sv
// Shared constants for the add_sub block: mode encodings and the default operand width.
package add_sub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; the ripple-carry cell of add_sub.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/add_sub.sv
// Registered ripple-carry adder/subtractor with carry, signed overflow and zero flags.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] result;

  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  // Subtract is A + ~B + 1: invert B and inject the +1 as the chain's carry-in.
  always_comb begin
    is_sub   = (mode == MODE_SUB);
    b_eff    = b ^ {WIDTH{is_sub}};
    chain[0] = is_sub;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (chain[i]),
      .s    (result[i]),
      .cout (chain[i+1])
    );
  end

  always_comb begin
    sum_d       = sum_q;
    carry_d     = carry_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d      = result;
      carry_d    = chain[WIDTH];
      overflow_d = chain[WIDTH] ^ chain[WIDTH-1];
      zero_d     = (result == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    sum       = sum_q;
    carry     = carry_q;
    overflow  = overflow_q;
    zero      = zero_q;
    out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_add_sub.sv
// Scoreboard bench for add_sub: stimulus pushes model results, a negedge monitor pops and compares.
module tb_add_sub;

  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    logic         z;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         out_valid;

  exp_t q[$];
  exp_t held = '0;
  int   checks = 0;
  int   failures = 0;

  add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: integer sums, unsigned compare for borrow, signed range for overflow.
  function automatic exp_t model(input int ua, input int ub, input logic m);
    exp_t e;
    int   sa, sb, full, sr, r;
    sa = (ua >= M / 2) ? ua - M : ua;
    sb = (ub >= M / 2) ? ub - M : ub;
    if (!m) begin
      full = ua + ub;
      e.c  = (full >= M);
      sr   = sa + sb;
    end else begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sr   = sa - sb;
    end
    r     = (full + M) % M;
    e.sum = r[W-1:0];
    e.o   = (sr > M / 2 - 1) || (sr < -(M / 2));
    e.z   = (r == 0);
    return e;
  endfunction

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got sum=%b c=%b o=%b z=%b, want sum=%b c=%b o=%b z=%b", name,
               act.sum, act.c, act.o, act.z, exp.sum, exp.c, exp.o, exp.z);
    end
  endtask

  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tm,
                       input logic tv);
    @(posedge clk);
    #1;
    a        = ta;
    b        = tb;
    mode     = tm;
    in_valid = tv;
    if (tv) q.push_back(model(int'(ta), int'(tb), tm));
  endtask

  task automatic check_reset_state(input string name);
    checks++;
    if ({sum, carry, overflow, zero, out_valid} !== '0) begin
      failures++;
      $display("FAIL %s: got sum=%b c=%b o=%b z=%b v=%b, want all zero", name, sum, carry,
               overflow, zero, out_valid);
    end
  endtask

  always @(negedge clk) begin
    exp_t act;
    if (!rst) begin
      act = {sum, carry, overflow, zero};
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: got out_valid=1, want 0 (queue empty)");
        end else begin
          exp_t e;
          e = q.pop_front();
          compare("result", act, e);
          held = e;
        end
      end else begin
        compare("hold", act, held);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset_initial");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors
    issue(4'b0101, 4'b0011, 1'b0, 1'b1);
    issue(4'b0101, 4'b0011, 1'b1, 1'b1);
    issue(4'b1000, 4'b0010, 1'b0, 1'b1);
    issue(4'b1000, 4'b0010, 1'b1, 1'b1);
    issue(4'b0011, 4'b0011, 1'b1, 1'b1);
    issue(4'b0010, 4'b0101, 1'b1, 1'b1);
    issue(4'b1111, 4'b0001, 1'b0, 1'b1);
    issue(4'b0000, 4'b0000, 1'b0, 1'b0);
    issue(4'b1111, 4'b1111, 1'b1, 1'b0);
    issue(4'b0111, 4'b0001, 1'b0, 1'b1);
    issue(4'b1000, 4'b0001, 1'b1, 1'b1);

    // Mid-stream reset between edges; the pending operation is discarded
    @(posedge clk);
    #1;
    a        = 4'b0110;
    b        = 4'b0001;
    mode     = 1'b0;
    in_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("reset_async");
    q.delete();
    held = '0;
    @(posedge clk);
    #1;
    check_reset_state("reset_held");
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    issue(4'b0000, 4'b0000, 1'b0, 1'b0);

    // Random stream with occasional idle cycles
    for (int i = 0; i < 300; i++) begin
      issue(W'($urandom_range(0, M - 1)), W'($urandom_range(0, M - 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending results, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
